// File: rtl/banked_data_memory.sv
// banked_data_memory: byte-banked data memory for the load/store path.
// NB = WIDTH/8 synchronous-read byte banks. Accesses that cross a row
// boundary take a second cycle to reach row+1 (wrapping at DEPTH-1).
// Ports:
//   clk_i, rst              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_we, req_funct3      store/load select, RISC-V access size/sign
//   req_addr, req_wdata     byte address, LSB-aligned store data
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      extended load data (0 for stores), illegal funct3
module banked_data_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048,
  localparam int NB     = WIDTH / 8,
  localparam int OFF    = $clog2(NB),
  localparam int ROW_W  = $clog2(DEPTH),
  localparam int ADDR_W = ROW_W + OFF
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_e;

  state_e                state_q;
  logic                  req_ready_q, rsp_valid_q, err_q, we_q, split_q;
  logic [2:0]            f3_q;
  logic [ROW_W-1:0]      row_q;
  logic [OFF-1:0]        off_q;
  logic [3:0]            size_q;
  logic [NB-1:0]         mask_q;
  logic [NB-1:0][7:0]    wlane_q, hold_q;

  logic [ROW_W-1:0]      row_in;
  logic [OFF-1:0]        off_in;
  logic [3:0]            size_in;
  logic                  illegal_in, split_in;
  logic [NB-1:0]         mask_in;
  logic [NB-1:0][7:0]    wd_bytes, wlane_in;

  logic                  bank_en;
  logic [ROW_W-1:0]      bank_addr;
  logic [NB-1:0]         bank_we;
  logic [NB-1:0][7:0]    bank_wd, bank_rd;

  logic [NB-1:0][7:0]    lane_b, ext;
  logic                  sgn;

  // Modulo-NB lane arithmetic: byte index carried by lane l, and lane holding byte i.
  function automatic logic [OFF-1:0] lane_sub(input int unsigned l, input logic [OFF-1:0] off);
    logic [OFF-1:0] lo;
    lo = OFF'(l);
    return lo - off;
  endfunction

  function automatic logic [OFF-1:0] lane_add(input int unsigned i, input logic [OFF-1:0] off);
    logic [OFF-1:0] lo;
    lo = OFF'(i);
    return lo + off;
  endfunction

  assign row_in   = req_addr[ADDR_W-1:OFF];
  assign off_in   = req_addr[OFF-1:0];
  assign wd_bytes = req_wdata;

  always_comb begin
    logic [OFF-1:0] idx;
    size_in    = 4'd1 << req_funct3[1:0];
    illegal_in = (req_funct3 == 3'd7) || (req_we && req_funct3[2]) ||
                 ((WIDTH == 32) && (req_funct3 == 3'd3 || req_funct3 == 3'd6));
    split_in   = !illegal_in && ((5'(off_in) + 5'(size_in)) > 5'(NB));
    mask_in    = '0;
    wlane_in   = '0;
    for (int unsigned l = 0; l < NB; l++) begin
      idx         = lane_sub(l, off_in);
      mask_in[l]  = 4'(idx) < size_in;
      wlane_in[l] = wd_bytes[idx];
    end
  end

  // Bank port: first row (low lanes) straight from the request in IDLE,
  // row+1 (high lanes) from the latched request in SPLIT.
  always_comb begin
    bank_en   = 1'b0;
    bank_addr = row_in;
    bank_we   = '0;
    bank_wd   = wlane_in;
    case (state_q)
      IDLE: begin
        bank_en = req_valid && !illegal_in;
        for (int unsigned l = 0; l < NB; l++)
          bank_we[l] = bank_en && req_we && mask_in[l] && (OFF'(l) >= off_in);
      end
      SPLIT: begin
        bank_en   = 1'b1;
        bank_addr = row_q + ROW_W'(1);
        bank_wd   = wlane_q;
        for (int unsigned l = 0; l < NB; l++)
          bank_we[l] = we_q && mask_q[l] && (OFF'(l) < off_q);
      end
      default: ;
    endcase
    if (rst) begin
      bank_en = 1'b0;
      bank_we = '0;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge clk_i) begin
      if (bank_en) begin
        if (bank_we[g]) mem[bank_addr] <= bank_wd[g];
        rd_q <= mem[bank_addr];
      end
    end
    assign bank_rd[g] = rd_q;
  end

  // Banks are idle in RESP, so their outputs (and hence rsp_rdata) stay
  // stable under backpressure; low lanes of a split come from hold_q.
  always_comb begin
    logic [OFF-1:0] src;
    sgn = 1'b0;
    ext = '0;
    for (int unsigned l = 0; l < NB; l++)
      lane_b[l] = (split_q && (OFF'(l) >= off_q)) ? hold_q[l] : bank_rd[l];
    for (int unsigned i = 0; i < NB; i++) begin
      src = lane_add(i, off_q);
      if (4'(i) < size_q) begin
        ext[i] = lane_b[src];
        if (4'(i + 1) == size_q) sgn = lane_b[src][7] & !f3_q[2];
      end else begin
        ext[i] = {8{sgn}};
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & err_q;
  assign rsp_rdata = (rsp_valid_q && !err_q && !we_q) ? ext : '0;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            row_q       <= row_in;
            off_q       <= off_in;
            size_q      <= size_in;
            f3_q        <= req_funct3;
            we_q        <= req_we;
            err_q       <= illegal_in;
            split_q     <= split_in;
            mask_q      <= mask_in;
            wlane_q     <= wlane_in;
            req_ready_q <= 1'b0;
            if (split_in) begin
              state_q <= SPLIT;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        SPLIT: begin
          hold_q      <= bank_rd;
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_data_memory.sv
// Directed bench for banked_data_memory: one 32-bit and one 64-bit instance.
module tb_banked_data_memory;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        c_valid, c_ready, c_we, c_rvalid, c_rready, c_err;
  logic [2:0]  c_f3;
  logic [12:0] c_addr;
  logic [31:0] c_wdata, c_rdata;

  logic        d_valid, d_ready, d_we, d_rvalid, d_rready, d_err;
  logic [2:0]  d_f3;
  logic [13:0] d_addr;
  logic [63:0] d_wdata, d_rdata;

  banked_data_memory #(.WIDTH(32), .DEPTH(2048)) dut32 (
    .clk_i(clk), .rst(rst),
    .req_valid(c_valid), .req_ready(c_ready), .req_we(c_we), .req_funct3(c_f3),
    .req_addr(c_addr), .req_wdata(c_wdata),
    .rsp_valid(c_rvalid), .rsp_ready(c_rready), .rsp_rdata(c_rdata), .rsp_err(c_err)
  );

  banked_data_memory #(.WIDTH(64), .DEPTH(2048)) dut64 (
    .clk_i(clk), .rst(rst),
    .req_valid(d_valid), .req_ready(d_ready), .req_we(d_we), .req_funct3(d_f3),
    .req_addr(d_addr), .req_wdata(d_wdata),
    .rsp_valid(d_rvalid), .rsp_ready(d_rready), .rsp_rdata(d_rdata), .rsp_err(d_err)
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] rd;
  logic        er;
  int          lat;

  // One complete transaction; lat = negedges from acceptance until rsp_valid.
  task automatic access(input bit w64, input bit we, input logic [2:0] f3,
                        input logic [13:0] addr, input logic [63:0] wd,
                        output logic [63:0] rdo, output logic erro, output int lato);
    int n;
    @(negedge clk);
    n = 0;
    while (!(w64 ? d_ready : c_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (w64) begin
      d_valid = 1'b1; d_we = we; d_f3 = f3; d_addr = addr; d_wdata = wd;
    end else begin
      c_valid = 1'b1; c_we = we; c_f3 = f3; c_addr = addr[12:0]; c_wdata = wd[31:0];
    end
    @(negedge clk);
    c_valid = 1'b0; c_we = 'x; c_f3 = 'x; c_addr = 'x; c_wdata = 'x;
    d_valid = 1'b0; d_we = 'x; d_f3 = 'x; d_addr = 'x; d_wdata = 'x;
    lato = 1;
    while (!(w64 ? d_rvalid : c_rvalid) && lato < 20) begin
      @(negedge clk);
      lato++;
    end
    rdo  = w64 ? d_rdata : {32'b0, c_rdata};
    erro = w64 ? d_err : c_err;
    if (w64) d_rready = 1'b1; else c_rready = 1'b1;
    @(negedge clk);
    c_rready = 1'b0;
    d_rready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    c_valid = 1'b0; d_valid = 1'b0; c_rready = 1'b0; d_rready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (c_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b exp 1", c_ready); end
    tests++; if (c_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", c_rvalid); end
    tests++; if (c_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h exp 0", c_rdata); end
    tests++; if (c_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b exp 0", c_err); end
    tests++; if (d_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready64 got %b exp 1", d_ready); end
    rst = 1'b0;
  endtask

  task automatic test_word;
    access(0, 1, 3'd2, 14'h0, 64'h11223344, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h0) begin fails++; $display("FAIL sw_rdata got %h exp 0", rd[31:0]); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL sw_latency got %0d exp 1", lat); end
    access(0, 0, 3'd2, 14'h0, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h11223344) begin fails++; $display("FAIL lw0 got %h exp 11223344", rd[31:0]); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL lw0_latency got %0d exp 1", lat); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL lw0_err got %b exp 0", er); end
  endtask

  task automatic test_byte_lanes;
    access(0, 1, 3'd2, 14'h4, 64'h01020304, rd, er, lat);
    access(0, 1, 3'd0, 14'h5, 64'h000000AA, rd, er, lat);
    access(0, 0, 3'd2, 14'h4, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h0102AA04) begin fails++; $display("FAIL sb_merge got %h exp 0102aa04", rd[31:0]); end
    access(0, 0, 3'd0, 14'h5, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'hFFFFFFAA) begin fails++; $display("FAIL lb got %h exp ffffffaa", rd[31:0]); end
    access(0, 0, 3'd4, 14'h5, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h000000AA) begin fails++; $display("FAIL lbu got %h exp 000000aa", rd[31:0]); end
  endtask

  task automatic test_split;
    access(0, 1, 3'd2, 14'h7, 64'hDEADBEEF, rd, er, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL sw_split_latency got %0d exp 2", lat); end
    access(0, 0, 3'd2, 14'h7, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_split got %h exp deadbeef", rd[31:0]); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL lw_split_latency got %0d exp 2", lat); end
    access(0, 0, 3'd1, 14'h7, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'hFFFFBEEF) begin fails++; $display("FAIL lh_split got %h exp ffffbeef", rd[31:0]); end
    access(0, 0, 3'd2, 14'h4, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'hEF02AA04) begin fails++; $display("FAIL split_low_row got %h exp ef02aa04", rd[31:0]); end
    access(0, 0, 3'd5, 14'h8, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h0000ADBE) begin fails++; $display("FAIL split_high_row got %h exp 0000adbe", rd[31:0]); end
  endtask

  task automatic test_wrap;
    access(0, 1, 3'd1, 14'h1FFF, 64'h8001, rd, er, lat);
    access(0, 0, 3'd5, 14'h1FFF, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h00008001) begin fails++; $display("FAIL lhu_wrap got %h exp 00008001", rd[31:0]); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL lhu_wrap_latency got %0d exp 2", lat); end
    access(0, 0, 3'd4, 14'h1FFF, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h00000001) begin fails++; $display("FAIL wrap_top_lane got %h exp 00000001", rd[31:0]); end
    access(0, 0, 3'd2, 14'h0, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h11223380) begin fails++; $display("FAIL wrap_row0 got %h exp 11223380", rd[31:0]); end
  endtask

  task automatic test_wide_and_illegal;
    access(1, 1, 3'd3, 14'h3, 64'h0123456789ABCDEF, rd, er, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL sd_split_latency got %0d exp 2", lat); end
    access(1, 0, 3'd3, 14'h3, 64'h0, rd, er, lat);
    tests++; if (rd !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL ld got %h exp 0123456789abcdef", rd); end
    access(1, 0, 3'd6, 14'h3, 64'h0, rd, er, lat);
    tests++; if (rd !== 64'h0000000089ABCDEF) begin fails++; $display("FAIL lwu got %h exp 0000000089abcdef", rd); end
    access(1, 0, 3'd2, 14'h3, 64'h0, rd, er, lat);
    tests++; if (rd !== 64'hFFFFFFFF89ABCDEF) begin fails++; $display("FAIL lw64 got %h exp ffffffff89abcdef", rd); end
    access(1, 0, 3'd4, 14'hA, 64'h0, rd, er, lat);
    tests++; if (rd !== 64'h1) begin fails++; $display("FAIL lbu64_high got %h exp 1", rd); end

    access(0, 1, 3'd2, 14'h10, 64'h12345678, rd, er, lat);
    access(0, 1, 3'd3, 14'h10, 64'hFFFFFFFF, rd, er, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL sd32_err got %b exp 1", er); end
    tests++; if (rd[31:0] !== 32'h0) begin fails++; $display("FAIL sd32_rdata got %h exp 0", rd[31:0]); end
    access(0, 0, 3'd2, 14'h10, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h12345678) begin fails++; $display("FAIL sd32_nowrite got %h exp 12345678", rd[31:0]); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL lw_after_err got %b exp 0", er); end
    access(0, 0, 3'd7, 14'h10, 64'h0, rd, er, lat);
    tests++; if (er !== 1'b1 || rd[31:0] !== 32'h0) begin fails++; $display("FAIL f3_7 got err=%b rdata=%h exp err=1 rdata=0", er, rd[31:0]); end
    access(0, 0, 3'd6, 14'h10, 64'h0, rd, er, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL lwu32_err got %b exp 1", er); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    c_valid = 1'b1; c_we = 1'b0; c_f3 = 3'd2; c_addr = 13'h0;
    @(negedge clk);
    // A store offered during RESP must be ignored.
    c_we = 1'b1; c_wdata = 32'h0BADBEEF;
    for (int i = 0; i < 5; i++) begin
      tests++; if (c_rvalid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b exp 1", i, c_rvalid); end
      tests++; if (c_rdata !== 32'h11223380) begin fails++; $display("FAIL bp_rdata[%0d] got %h exp 11223380", i, c_rdata); end
      tests++; if (c_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready[%0d] got %b exp 0", i, c_ready); end
      @(negedge clk);
    end
    c_valid = 1'b0;
    c_rready = 1'b1;
    @(negedge clk);
    c_rready = 1'b0;
    tests++; if (c_ready !== 1'b1) begin fails++; $display("FAIL bp_release got %b exp 1", c_ready); end
    access(0, 0, 3'd2, 14'h0, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h11223380) begin fails++; $display("FAIL bp_ignored_store got %h exp 11223380", rd[31:0]); end
  endtask

  task automatic test_reset_mid_split;
    @(negedge clk);
    c_valid = 1'b1; c_we = 1'b1; c_f3 = 3'd2; c_addr = 13'h6; c_wdata = 32'hCAFEF00D;
    @(negedge clk);
    c_valid = 1'b0;
    tests++; if (c_rvalid !== 1'b0) begin fails++; $display("FAIL split_no_valid got %b exp 0", c_rvalid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (c_rvalid !== 1'b0) begin fails++; $display("FAIL rst_split_valid got %b exp 0", c_rvalid); end
    tests++; if (c_ready !== 1'b1) begin fails++; $display("FAIL rst_split_ready got %b exp 1", c_ready); end
    access(0, 0, 3'd1, 14'h6, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'hFFFFF00D) begin fails++; $display("FAIL rst_split_low got %h exp fffff00d", rd[31:0]); end
    access(0, 0, 3'd5, 14'h8, 64'h0, rd, er, lat);
    tests++; if (rd[31:0] !== 32'h0000ADBE) begin fails++; $display("FAIL rst_split_high got %h exp 0000adbe", rd[31:0]); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_split();
    test_wrap();
    test_wide_and_illegal();
    test_backpressure();
    test_reset_mid_split();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1);
  end

endmodule
